// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer.
// Walks each instruction through FETCH/DECODE and its per-opcode states,
// driving datapath mux selects and write enables. The shared memory port
// uses a req/ready handshake with a wait timeout that traps into HALT.
//
// Memory handshake: mem_req is held high for the whole of FETCH, MEMRD and
// MEMWR. The access completes in the cycle where mem_req=1 and mem_ready=1;
// the enables that depend on the access (IRWrite/PCWrite in FETCH, retire in
// MEMWR) are qualified by mem_ready in that same cycle. mem_ready is ignored
// whenever mem_req is low.

module multicycle_control #(
    parameter int unsigned WAIT_MAX        = 15,
    parameter bit          TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       retire,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state_o
);

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Wait counter is just wide enough to reach WAIT_MAX.
    localparam int unsigned    CW       = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  WAIT_LIM = CW'(WAIT_MAX);
    localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          access;
    logic          timeout;

    // A memory access is in progress in exactly these three states.
    assign access = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Timeout fires on the stalled cycle that finds the counter already at the limit.
    assign timeout = (WAIT_MAX != 0) && access && !mem_ready && (wait_cnt_q == WAIT_LIM);

    assign state_o = state_q;
    assign bus_err = bus_err_q;

    // State register; reset lands in FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter and sticky bus error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Wait counter: restart on entry to an access state, count stalled cycles, saturate.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (access && !mem_ready && (wait_cnt_q != CNT_SAT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR))) begin
            wait_cnt_d = '0;
        end
        bus_err_d = bus_err_q | timeout;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // PC + 4 computed on the ALU while the instruction is read.
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                ALUSrcB = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                // PC loads ALUOut only if the subtract gives zero.
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                // Only reset leaves HALT.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // A memory port that never answers parks the sequencer.
        if (timeout) begin
            state_d = S_HALT;
        end

        // During reset the state already reads FETCH, so selects keep their
        // FETCH values; only the enables, strobes, request and pulses are forced low.
        if (!rst_n) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            retire     = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Two instances share all inputs: u_a (WAIT_MAX=4, illegal -> FETCH) and
// u_b (WAIT_MAX=15, illegal -> HALT).

module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       a_mem_req, a_IorD, a_MemWrite, a_IRWrite, a_PCWrite, a_Branch;
    logic [1:0] a_PCSrc, a_ALUSrcB, a_ALUOp;
    logic       a_ALUSrcA, a_RegWrite, a_RegDst, a_MemtoReg, a_retire, a_illegal_op, a_bus_err;
    logic [3:0] a_state;

    logic       b_mem_req, b_IorD, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch;
    logic [1:0] b_PCSrc, b_ALUSrcB, b_ALUOp;
    logic       b_ALUSrcA, b_RegWrite, b_RegDst, b_MemtoReg, b_retire, b_illegal_op, b_bus_err;
    logic [3:0] b_state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.WAIT_MAX(4), .TRAP_ON_ILLEGAL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .IorD(a_IorD), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
        .PCWrite(a_PCWrite), .Branch(a_Branch), .PCSrc(a_PCSrc), .ALUSrcA(a_ALUSrcA),
        .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .RegWrite(a_RegWrite), .RegDst(a_RegDst),
        .MemtoReg(a_MemtoReg), .retire(a_retire), .illegal_op(a_illegal_op),
        .bus_err(a_bus_err), .state_o(a_state)
    );

    multicycle_control #(.WAIT_MAX(15), .TRAP_ON_ILLEGAL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .PCWrite(b_PCWrite), .Branch(b_Branch), .PCSrc(b_PCSrc), .ALUSrcA(b_ALUSrcA),
        .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .RegWrite(b_RegWrite), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .retire(b_retire), .illegal_op(b_illegal_op),
        .bus_err(b_bus_err), .state_o(b_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = OP_LW;
        #2;
        // Reset: FETCH, enables low even with mem_ready high, FETCH selects.
        chk("rst_state",    8'(a_state),   8'd0);
        chk("rst_mem_req",  8'(a_mem_req), 8'd0);
        chk("rst_irwrite",  8'(a_IRWrite), 8'd0);
        chk("rst_pcwrite",  8'(a_PCWrite), 8'd0);
        chk("rst_bus_err",  8'(a_bus_err), 8'd0);
        chk("rst_alusrcb",  8'(a_ALUSrcB), 8'd1);
        chk("rst_b_memreq", 8'(b_mem_req), 8'd0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        // lw with mem_ready tied high: 0,1,2,3,4,0
        chk("lw_fetch_state", 8'(a_state),   8'd0);
        chk("lw_fetch_req",   8'(a_mem_req), 8'd1);
        chk("lw_fetch_irw",   8'(a_IRWrite), 8'd1);
        chk("lw_fetch_pcw",   8'(a_PCWrite), 8'd1);
        chk("lw_fetch_iord",  8'(a_IorD),    8'd0);
        step();
        chk("lw_dec_state",   8'(a_state),      8'd1);
        chk("lw_dec_alusrcb", 8'(a_ALUSrcB),    8'd3);
        chk("lw_dec_illegal", 8'(a_illegal_op), 8'd0);
        step();
        chk("lw_adr_state",   8'(a_state),   8'd2);
        chk("lw_adr_alusrca", 8'(a_ALUSrcA), 8'd1);
        chk("lw_adr_alusrcb", 8'(a_ALUSrcB), 8'd2);
        step();
        chk("lw_rd_state",    8'(a_state),    8'd3);
        chk("lw_rd_req",      8'(a_mem_req),  8'd1);
        chk("lw_rd_iord",     8'(a_IorD),     8'd1);
        chk("lw_rd_regwrite", 8'(a_RegWrite), 8'd0);
        step();
        chk("lw_wb_state",    8'(a_state),    8'd4);
        chk("lw_wb_regwrite", 8'(a_RegWrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(a_MemtoReg), 8'd1);
        chk("lw_wb_regdst",   8'(a_RegDst),   8'd0);
        chk("lw_wb_retire",   8'(a_retire),   8'd1);
        step();
        chk("lw_end_state",    8'(a_state),    8'd0);
        chk("lw_end_regwrite", 8'(a_RegWrite), 8'd0);
        chk("lw_end_retire",   8'(a_retire),   8'd0);
        opcode = OP_SW;

        // sw with mem_ready low for 3 cycles in MEMWR
        step();
        chk("sw_dec_state", 8'(a_state), 8'd1);
        step();
        chk("sw_adr_state", 8'(a_state), 8'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw_wait_state",    8'(a_state),    8'd5);
            chk("sw_wait_memwrite", 8'(a_MemWrite), 8'd1);
            chk("sw_wait_req",      8'(a_mem_req),  8'd1);
            chk("sw_wait_retire",   8'(a_retire),   8'd0);
            chk("sw_wait_regwrite", 8'(a_RegWrite), 8'd0);
        end
        step();
        mem_ready = 1'b1;
        #1;
        chk("sw_done_state",    8'(a_state),    8'd5);
        chk("sw_done_memwrite", 8'(a_MemWrite), 8'd1);
        chk("sw_done_retire",   8'(a_retire),   8'd1);
        chk("sw_done_regwrite", 8'(a_RegWrite), 8'd0);
        step();
        chk("sw_end_state",    8'(a_state),    8'd0);
        chk("sw_end_memwrite", 8'(a_MemWrite), 8'd0);
        opcode = OP_BEQ;

        // beq: 0,1,8
        step();
        chk("beq_dec_state", 8'(a_state), 8'd1);
        step();
        chk("beq_state",   8'(a_state),   8'd8);
        chk("beq_branch",  8'(a_Branch),  8'd1);
        chk("beq_pcsrc",   8'(a_PCSrc),   8'd1);
        chk("beq_aluop",   8'(a_ALUOp),   8'd1);
        chk("beq_pcwrite", 8'(a_PCWrite), 8'd0);
        chk("beq_retire",  8'(a_retire),  8'd1);
        step();
        chk("beq_end_state", 8'(a_state), 8'd0);
        opcode = OP_J;

        // j: 0,1,11
        step();
        chk("j_dec_state", 8'(a_state), 8'd1);
        step();
        chk("j_state",   8'(a_state),   8'd11);
        chk("j_pcwrite", 8'(a_PCWrite), 8'd1);
        chk("j_pcsrc",   8'(a_PCSrc),   8'd2);
        chk("j_branch",  8'(a_Branch),  8'd0);
        chk("j_retire",  8'(a_retire),  8'd1);
        step();
        chk("j_end_state", 8'(a_state), 8'd0);
        opcode = OP_BAD;

        // Illegal opcode: u_a back to FETCH, u_b to HALT
        step();
        chk("ill_dec_state",  8'(a_state),      8'd1);
        chk("ill_a_pulse",    8'(a_illegal_op), 8'd1);
        chk("ill_b_pulse",    8'(b_illegal_op), 8'd1);
        chk("ill_regwrite",   8'(a_RegWrite),   8'd0);
        chk("ill_memwrite",   8'(a_MemWrite),   8'd0);
        chk("ill_retire",     8'(a_retire),     8'd0);
        step();
        chk("ill_a_state",    8'(a_state),      8'd0);
        chk("ill_a_pulse_lo", 8'(a_illegal_op), 8'd0);
        chk("ill_b_state",    8'(b_state),      8'd12);
        chk("ill_b_req",      8'(b_mem_req),    8'd0);
        opcode = OP_RTYPE;

        // R-type on u_a while u_b stays halted
        step();
        chk("r_dec_state", 8'(a_state), 8'd1);
        chk("r_b_halt",    8'(b_state), 8'd12);
        step();
        chk("r_exe_state",   8'(a_state),   8'd6);
        chk("r_exe_alusrca", 8'(a_ALUSrcA), 8'd1);
        chk("r_exe_alusrcb", 8'(a_ALUSrcB), 8'd0);
        chk("r_exe_aluop",   8'(a_ALUOp),   8'd2);
        step();
        chk("r_wb_state",    8'(a_state),    8'd7);
        chk("r_wb_regwrite", 8'(a_RegWrite), 8'd1);
        chk("r_wb_regdst",   8'(a_RegDst),   8'd1);
        chk("r_wb_memtoreg", 8'(a_MemtoReg), 8'd0);
        chk("r_wb_retire",   8'(a_retire),   8'd1);
        step();
        chk("r_end_state", 8'(a_state), 8'd0);
        opcode = OP_ADDI;

        // addi: 0,1,9,10
        step();
        chk("addi_dec_state", 8'(a_state), 8'd1);
        step();
        chk("addi_ex_state",   8'(a_state),   8'd9);
        chk("addi_ex_alusrcb", 8'(a_ALUSrcB), 8'd2);
        chk("addi_ex_alusrca", 8'(a_ALUSrcA), 8'd1);
        step();
        chk("addi_wb_state",    8'(a_state),    8'd10);
        chk("addi_wb_regwrite", 8'(a_RegWrite), 8'd1);
        chk("addi_wb_regdst",   8'(a_RegDst),   8'd0);
        chk("addi_wb_retire",   8'(a_retire),   8'd1);
        chk("addi_b_halt",      8'(b_state),    8'd12);
        chk("addi_b_retire",    8'(b_retire),   8'd0);
        step();
        chk("addi_end_state", 8'(a_state), 8'd0);

        // Reset pulse releases u_b; then FETCH timeout on u_a (WAIT_MAX=4)
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rp_b_state", 8'(b_state),   8'd0);
        chk("rp_a_req",   8'(a_mem_req), 8'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("to_w1_state", 8'(a_state),   8'd0);
        chk("to_w1_req",   8'(a_mem_req), 8'd1);
        chk("to_w1_irw",   8'(a_IRWrite), 8'd0);
        chk("to_w1_pcw",   8'(a_PCWrite), 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_wait_state",   8'(a_state),   8'd0);
            chk("to_wait_bus_err", 8'(a_bus_err), 8'd0);
        end
        step();
        chk("to_halt_state",   8'(a_state),   8'd12);
        chk("to_halt_bus_err", 8'(a_bus_err), 8'd1);
        chk("to_halt_req",     8'(a_mem_req), 8'd0);
        chk("to_b_state",      8'(b_state),   8'd0);
        chk("to_b_bus_err",    8'(b_bus_err), 8'd0);
        mem_ready = 1'b1;
        step();
        chk("to_stuck_state",   8'(a_state),   8'd12);
        chk("to_stuck_bus_err", 8'(a_bus_err), 8'd1);
        chk("to_stuck_irw",     8'(a_IRWrite), 8'd0);
        step();
        chk("to_stuck2_state", 8'(a_state), 8'd12);

        // Reset clears HALT and bus_err
        rst_n = 1'b0;
        #1;
        chk("rc_state",   8'(a_state),   8'd0);
        chk("rc_bus_err", 8'(a_bus_err), 8'd0);
        step();
        rst_n  = 1'b1;
        opcode = OP_SW;
        #1;
        chk("rc_rel_state", 8'(a_state),   8'd0);
        chk("rc_rel_req",   8'(a_mem_req), 8'd1);

        // Reset asserted in the middle of a MEMWR stall
        step();
        chk("mr_dec_state", 8'(a_state), 8'd1);
        step();
        chk("mr_adr_state", 8'(a_state), 8'd2);
        mem_ready = 1'b0;
        step();
        chk("mr_wr_state",    8'(a_state),    8'd5);
        chk("mr_wr_memwrite", 8'(a_MemWrite), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_memwrite", 8'(a_MemWrite), 8'd0);
        chk("mr_rst_req",      8'(a_mem_req),  8'd0);
        chk("mr_rst_state",    8'(a_state),    8'd0);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mr_rel_state",   8'(a_state),   8'd0);
        chk("mr_rel_bus_err", 8'(a_bus_err), 8'd0);
        chk("mr_rel_req",     8'(a_mem_req), 8'd1);
        step();
        chk("mr_next_state", 8'(a_state), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
